// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm ring sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_ALARM = 2'b01,
    SRC_TIMER = 2'b10
  } src_e;

  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter; decrements on tick and saturates at zero.
module sec_down_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         at_one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign at_one = (count == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Ring/snooze sequencer for the alarm chaser: serialises alarm and timer
// requests and times each ring and snooze from the 1 Hz tick.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       SW,
  input  logic       alarm_hit,
  input  logic       timer_done,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       sign,
  output logic [1:0] src,
  output logic [1:0] pend,
  output logic [1:0] snooze_cnt
);

  localparam int CW = cnt_width(RING_SECS, SNOOZE_SECS);
  localparam logic [CW-1:0] RING_LD   = CW'(RING_SECS);
  localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_SECS);
  localparam logic [1:0]    MAX_SNZ   = 2'(MAX_SNOOZE);

  state_e        state, state_n;
  src_e          src_q, src_n;
  logic [1:0]    pend_q, pend_n;
  logic [1:0]    snz_q, snz_n;
  logic [1:0]    req;
  logic          load;
  logic [CW-1:0] load_val;
  logic          at_one;

  sec_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (tick_1hz),
    .at_one   (at_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      src_q  <= SRC_NONE;
      pend_q <= '0;
      snz_q  <= '0;
    end else begin
      state  <= state_n;
      src_q  <= src_n;
      pend_q <= pend_n;
      snz_q  <= snz_n;
    end
  end

  always_comb begin
    state_n  = state;
    src_n    = src_q;
    snz_n    = snz_q;
    load     = 1'b0;
    load_val = '0;
    req      = {timer_done, alarm_hit};
    // The source currently ringing does not re-pend itself.
    if (state == RING && src_q == SRC_ALARM) req[0] = 1'b0;
    if (state == RING && src_q == SRC_TIMER) req[1] = 1'b0;
    pend_n = pend_q | req;

    if (!SW) begin
      state_n = IDLE;
      src_n   = SRC_NONE;
      pend_n  = '0;
      snz_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend_n[1]) begin
            state_n   = RING;
            src_n     = SRC_TIMER;
            pend_n[1] = 1'b0;
            load      = 1'b1;
            load_val  = RING_LD;
          end else if (pend_n[0]) begin
            state_n   = RING;
            src_n     = SRC_ALARM;
            pend_n[0] = 1'b0;
            load      = 1'b1;
            load_val  = RING_LD;
          end
        end
        RING: begin
          if (key_stop || (tick_1hz && at_one)) begin
            if (!key_stop && key_snooze && src_q == SRC_ALARM && snz_q < MAX_SNZ) begin
              state_n  = SNOOZE;
              load     = 1'b1;
              load_val = SNOOZE_LD;
              snz_n    = snz_q + 2'd1;
            end else begin
              state_n = IDLE;
              src_n   = SRC_NONE;
              snz_n   = '0;
            end
          end else if (key_snooze && src_q == SRC_ALARM && snz_q < MAX_SNZ) begin
            state_n  = SNOOZE;
            load     = 1'b1;
            load_val = SNOOZE_LD;
            snz_n    = snz_q + 2'd1;
          end
        end
        SNOOZE: begin
          if (key_stop) begin
            state_n = IDLE;
            src_n   = SRC_NONE;
            snz_n   = '0;
          end else if (pend_n[1]) begin
            // Timer preempts the snooze; the alarm is re-queued behind it.
            state_n   = RING;
            src_n     = SRC_TIMER;
            pend_n[1] = 1'b0;
            pend_n[0] = 1'b1;
            snz_n     = '0;
            load      = 1'b1;
            load_val  = RING_LD;
          end else if (tick_1hz && at_one) begin
            state_n  = RING;
            load     = 1'b1;
            load_val = RING_LD;
          end
        end
        default: begin
          state_n = IDLE;
          src_n   = SRC_NONE;
        end
      endcase
    end
  end

  assign sign       = (state == RING);
  assign src        = src_q;
  assign pend       = pend_q;
  assign snooze_cnt = snz_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Sequencer for the alarm light chaser. It accepts ring requests from two sources: the clock-alarm time match and the countdown-timer expiry. It serialises the requests, generates the `sign` enable that drives the chaser, and times each ring and snooze in seconds from the 1 Hz tick. It sits between the time-keeping blocks and the chaser, gated by the same `SW` enable switch.

## Interface
- `RING_SECS`, default 30: ring duration in seconds before auto-stop.
- `SNOOZE_SECS`, default 300: snooze length in seconds.
- `MAX_SNOOZE`, default 3: maximum snoozes per alarm ring episode.
- `clk`  in  1  system clock; the one clock of the block.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick_1hz`  in  1  one-`clk`-wide pulse, once per second.
- `SW`  in  1  alarm enable switch; 0 forces silence.
- `alarm_hit`  in  1  one-cycle pulse when current time equals the alarm time.
- `timer_done`  in  1  one-cycle pulse when the countdown timer reaches zero.
- `key_stop`  in  1  debounced single-cycle stop pulse.
- `key_snooze`  in  1  debounced single-cycle snooze pulse.
- `sign`  out  1  ring enable to the chaser; 1 only in RING.
- `src`  out  2  source being served: 00 none, 01 alarm, 10 timer.
- `pend`  out  2  latched waiting requests: bit0 alarm, bit1 timer.
- `snooze_cnt`  out  2  snoozes taken in the current alarm episode.

## Operation
- **Reset values.** All outputs are 0 on reset. State is IDLE. The seconds counter is 0.
- **States.** The block has three states: IDLE, RING and SNOOZE.
- **Request latching.**
  - A request pulse sets its `pend` bit.
  - A request is not latched while `SW`=0.
  - A request is not latched if its source is the one currently in RING.
- **IDLE.**
  - If `pend | {timer_done, alarm_hit}` is non-zero, the block enters RING.
  - The timer source has priority over the alarm source.
  - On entry: the chosen `pend` bit is cleared, `src` is set, and the counter is loaded with `RING_SECS`.
- **RING.**
  - `sign`=1.
  - Each tick decrements the counter.
  - A tick with counter=1 is a timeout and goes to IDLE.
  - `key_stop` goes to IDLE.
  - On any exit to IDLE: `src`=00, and `snooze_cnt`=0.
- **Snooze.**
  - `key_snooze` is accepted only when `src`=01 and `snooze_cnt`<`MAX_SNOOZE`.
  - When accepted: go to SNOOZE, load `SNOOZE_SECS`, increment `snooze_cnt`.
  - Otherwise `key_snooze` is ignored.
- **SNOOZE.**
  - `sign`=0, and `src` stays 01.
  - Each tick decrements the counter; a tick with counter=1 returns to RING with `RING_SECS` reloaded.
  - `key_stop` goes to IDLE and clears `snooze_cnt`.
  - **Timer preemption.** If `pend[1]` is set or `timer_done` arrives:
    - the snooze is abandoned;
    - `pend[0]` is set and `snooze_cnt` is cleared;
    - the block enters RING with `src`=10 and `RING_SECS` loaded.
- **`SW`=0.** At the next edge the state goes to IDLE and all outputs clear. This overrides every other event.
- **Event priority** (highest first): `SW`=0, then `key_stop`, then timer preemption, then `key_snooze`, then tick expiry.
- **Counter.** Width is `$clog2(max(RING_SECS, SNOOZE_SECS)+1)`. It is unsigned and never wraps below 0. Non-tick cycles hold its value.

## Timing
- All registers update on `posedge clk` or `negedge rst`.
- **Request latency.** A request pulse sampled at edge k, with state IDLE, gives `sign`=1 from edge k. This is one registered stage and there is no extra cycle.
- **Stop latency.** `key_stop` sampled at edge k gives `sign`=0 after edge k.
- **Ring length.** Exactly `RING_SECS` ticks from entry to timeout.
- **Snooze length.** Exactly `SNOOZE_SECS` ticks from entry to re-ring.
- **Back-to-back requests.** A waiting request starts at the edge after the IDLE entry. `sign` drops for exactly one cycle between back-to-back rings.
- **Same-cycle events.**
  - `alarm_hit` and `timer_done` together in IDLE: timer rings, alarm is pended.
  - `key_stop` and `key_snooze` together: stop wins.
  - A tick in the same cycle as a key: the key wins, and the tick is dropped for that state.
- **Reset mid-ring.** `sign` falls immediately (asynchronously). Pending requests are lost.

## Structure
- Package `alarm_pkg` holds:
  - the state enum (IDLE=0, RING=1, SNOOZE=2);
  - the `src` codes (SRC_NONE, SRC_ALARM, SRC_TIMER);
  - the counter-width function.
- Sub-module `sec_down_counter` provides:
  - inputs: `load`, `load_val`, and `tick` enable;
  - a saturating decrement;
  - an `at_one` flag used for expiry detection.
- `alarm_ctrl` instantiates one `sec_down_counter` and holds the FSM and `pend`/`snooze_cnt` registers.

## Test plan
Bench parameters: `RING_SECS`=3, `SNOOZE_SECS`=4, `MAX_SNOOZE`=2. The tick fires every 5 `clk`.
- **Timeout.** `SW`=1, `alarm_hit` pulse → `sign`=1 and `src`=01 at the next edge; `sign`=0 and `src`=00 after the 3rd tick.
- **Snooze limit.**
  - Alarm, then `key_snooze` → SNOOZE with `snooze_cnt`=1, then `sign`=1 again after 4 ticks.
  - A second snooze gives `snooze_cnt`=2.
  - A third `key_snooze` is ignored: `sign` stays 1 until the 3-tick timeout.
- **Simultaneous requests.** `alarm_hit` and `timer_done` in the same cycle → `src`=10 and `pend`=01. After `key_stop`, `sign` is low for exactly one cycle, then `src`=01.
- **Preemption.** `timer_done` during SNOOZE → RING with `src`=10, `pend`=01, `snooze_cnt`=0.
- **Key conflict.** `key_stop` and `key_snooze` in the same cycle → IDLE, `snooze_cnt`=0.
- **Overrides.**
  - `SW`=0 mid-RING → all outputs 0 at the next edge; an `alarm_hit` while `SW`=0 leaves `pend`=00.
  - Async `rst` low mid-RING → `sign`=0 before the next `clk` edge.
